// File: rtl/arr_feeder.sv
// rtl/arr_feeder.sv - operand store and skewed stream feeder for a 2x2 systolic array
module arr_feeder #(
    parameter int DW        = 8,
    parameter int FLUSH_CYC = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [2:0]    load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] w1_out,
    output logic [DW-1:0] w2_out,
    output logic [DW-1:0] a1_out,
    output logic [DW-1:0] a2_out,
    output logic          arr_hold
);

    localparam int CMAX = (FLUSH_CYC > 3) ? FLUSH_CYC : 3;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] opr [0:7];
    logic          load_fire;

    assign load_ready = (state == IDLE);
    assign load_fire  = load_valid & load_ready;
    assign arr_hold   = stall & busy;

    // opr[0..3] = W11,W12,W21,W22 ; opr[4..7] = A11,A12,A21,A22
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                opr[i] <= '0;
            end
        end else if (load_fire) begin
            opr[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            w1_out <= '0;
            w2_out <= '0;
            a1_out <= '0;
            a2_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a simultaneous load takes priority over start
                    if (start && !load_valid) begin
                        state  <= FEED;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        w1_out <= opr[0];
                        w2_out <= '0;
                        a1_out <= opr[4];
                        a2_out <= '0;
                    end
                end
                FEED: begin
                    if (!stall) begin
                        if (cnt == CW'(2)) begin
                            state  <= FLUSH;
                            cnt    <= '0;
                            w1_out <= '0;
                            w2_out <= '0;
                            a1_out <= '0;
                            a2_out <= '0;
                        end else if (cnt == CW'(0)) begin
                            cnt    <= cnt + CW'(1);
                            w1_out <= opr[1];
                            w2_out <= opr[2];
                            a1_out <= opr[6];
                            a2_out <= opr[5];
                        end else begin
                            cnt    <= cnt + CW'(1);
                            w1_out <= '0;
                            w2_out <= opr[3];
                            a1_out <= '0;
                            a2_out <= opr[7];
                        end
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        if (cnt == CW'(FLUSH_CYC - 1)) begin
                            state <= DONE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/arr_feeder.md
ARR_FEEDER -- requirements
Module: arr_feeder

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning operand width in bits; the block SHALL pass operands bit-exact with no sign handling.
REQ-002 The block SHALL have parameter FLUSH_CYC, default 3, meaning the number of zero-drive cycles after the feed slots; the legal range SHALL be 1..15.
REQ-003 Ports (name  direction  width  meaning):
  clk  in  1  single clock; all state changes on the rising edge
  rst_n  in  1  asynchronous, active-low reset
  load_valid  in  1  operand write request
  load_ready  out  1  write accepted when high; high only in IDLE
  load_addr  in  3  [2]=0 W / 1 A; [1:0]={row,col}: 0=X11, 1=X12, 2=X21, 3=X22
  load_data  in  DW  operand value
  start  in  1  one-cycle request to feed the 2x2 array
  stall  in  1  downstream freeze request
  busy  out  1  high while feeding or flushing
  done  out  1  one-cycle pulse after the last flush cycle
  w1_out, w2_out  out  DW  weight streams to the array's w1_in/w2_in
  a1_out, a2_out  out  DW  activation streams to the array's a1_in/a2_in
  arr_hold  out  1  hold to the array; combinational, equal to stall AND busy

Function
REQ-004 Operand storage SHALL be 8 registers of DW bits (W11..W22, A11..A22); a write SHALL occur at a rising edge when load_valid and load_ready are both high.
REQ-005 The FSM SHALL have states IDLE, FEED, FLUSH and DONE.
REQ-006 IDLE->FEED SHALL occur on start=1 and load_valid=0; if start and load_valid are both high in IDLE, the load SHALL win and start SHALL be ignored.
REQ-007 start outside IDLE SHALL be ignored; load_valid outside IDLE SHALL be ignored (load_ready=0).
REQ-008 FEED SHALL last 3 slots (k=0,1,2); the stream registers SHALL be loaded at the edge that enters slot k, as follows:
  - slot 0: w1=W11, w2=0, a1=A11, a2=0
  - slot 1: w1=W12, w2=W21, a1=A21, a2=A12
  - slot 2: w1=0, w2=W22, a1=0, a2=A22
REQ-009 FLUSH SHALL last FLUSH_CYC cycles with all four stream outputs at 0; at the following edge the FSM SHALL enter DONE.
REQ-010 DONE SHALL last exactly one cycle with done=1 and busy=0, and SHALL then go to IDLE; a start seen during DONE SHALL be ignored.
REQ-011 busy SHALL be 1 in FEED and FLUSH and 0 otherwise; with no stall, busy SHALL be high for 3+FLUSH_CYC cycles.
REQ-012 When stall=1 at an edge while busy=1, the slot counter, state and stream outputs SHALL hold their values; stall in IDLE or DONE SHALL have no effect, and arr_hold SHALL be 0 then.
REQ-013 The slot counter SHALL be wide enough for max(3, FLUSH_CYC) and SHALL reset to 0 on each phase entry; there SHALL be no wrap-around into a new feed without a new start.
REQ-014 Operand registers SHALL NOT change during FEED or FLUSH, so the streamed values are those present at the start edge.

Reset
REQ-015 While rst_n=0, asynchronously: state=IDLE, counter=0, all operand registers=0, w1/w2/a1/a2_out=0, busy=0, done=0, arr_hold=0, load_ready=1 once IDLE.
REQ-016 A reset asserted mid-FEED or mid-FLUSH SHALL abort the operation with no done pulse; after release the block SHALL be in IDLE with cleared operands.

Verification
REQ-017 Load W=[1,2;3,4] and A=[5,6;7,8] (addr 0..7), then start -> slots show (w1,w2,a1,a2) = (1,0,5,0), (2,3,7,6), (0,4,0,8); then 3 cycles of zeros; done high 1 cycle; busy high exactly 6 cycles.
REQ-018 Hold stall=1 for 2 cycles during slot 1 -> outputs stay at (2,3,7,6), arr_hold=1 for those 2 cycles, busy lasts 8 cycles, and done is delayed by 2 cycles.
REQ-019 Assert start and load_valid in the same IDLE cycle (addr 0, data 9) -> W11=9, no feed begins; a later start streams w1=9 in slot 0.
REQ-020 Pulse start during FEED slot 1 and during DONE -> no restart, exactly one done pulse.
REQ-021 Assert rst_n=0 in FLUSH cycle 1 -> outputs 0 immediately, no done; a subsequent start without load streams all zeros.
REQ-022 Issue load_valid during busy (addr 4, data 0xFF) -> load_ready=0, A11 unchanged; the next run still streams a1=5 in slot 0.
